// File: rtl/ro_seq_pkg.sv
// Shared types and helpers for the ring-oscillator measurement sequencer.
package ro_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_GATE,
        S_DRAIN,
        S_REPORT
    } seq_state_t;

    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_DRAIN_CYC  = 3;

    // Largest supported oscillator bank; mask searches are done at this width
    localparam int MAX_RO = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } bit_search_t;

    // Lowest set bit of mask at or above position 'from'
    function automatic bit_search_t next_set_bit(input logic [MAX_RO-1:0] mask,
                                                 input logic [3:0]        from);
        bit_search_t res;
        res.found = 1'b0;
        res.idx   = 3'd0;
        for (int b = 0; b < MAX_RO; b++) begin
            if (!res.found && (4'(b) >= from) && mask[b]) begin
                res.found = 1'b1;
                res.idx   = 3'(b);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ro_seq_timer.sv
// Loadable down-counter shared by the settle, gate and drain phases.
// Loading N-1 makes o_done assert on the N-th cycle after the load.
module ro_seq_timer
    import ro_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Count down to zero and hold there until the next load
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/ro_measure_sequencer.sv
// Steps the RO bank through a masked sweep: enable, settle, gate the edge
// counter, let the synchronizer drain, then hand the count to the consumer.
module ro_measure_sequencer
    import ro_seq_pkg::*;
#(
    parameter int NUM_RO     = 4,
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 16,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int DRAIN_CYC  = DEF_DRAIN_CYC,
    localparam int ID_W      = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic [NUM_RO-1:0] i_ro_mask,
    input  logic [GATE_W-1:0] i_gate_cycles,
    output logic [NUM_RO-1:0] o_ro_en,
    output logic              o_cnt_clear,
    output logic              o_cnt_gate,
    input  logic [CNT_W-1:0]  i_cnt_value,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [CNT_W-1:0]  o_res_data,
    output logic [ID_W-1:0]   o_res_id,
    output logic              o_busy
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int DRN_W = $clog2(DRAIN_CYC + 1);
    localparam int TMR_W = (GATE_W > SET_W) ? ((GATE_W > DRN_W) ? GATE_W : DRN_W)
                                            : ((SET_W > DRN_W) ? SET_W : DRN_W);

    seq_state_t        r_state;
    seq_state_t        w_stateNext;
    logic [NUM_RO-1:0] r_mask;
    logic [GATE_W-1:0] r_gate;
    logic [2:0]        r_idx;
    logic [CNT_W-1:0]  r_resData;
    logic [ID_W-1:0]   r_resId;

    bit_search_t       w_lowSearch;
    bit_search_t       w_nextSearch;
    logic              w_latchCfg;
    logic              w_idxLoad;
    logic [2:0]        w_idxNew;
    logic              w_capture;
    logic              w_tmrLoad;
    logic [TMR_W-1:0]  w_tmrVal;
    logic              w_tmrDone;
    logic [TMR_W-1:0]  w_gateLoad;
    logic [NUM_RO-1:0] w_onehot;

    // First oscillator of a fresh sweep comes from the live mask input,
    // later ones from the mask latched when the sweep began
    assign w_lowSearch  = next_set_bit(MAX_RO'(i_ro_mask), 4'd0);
    assign w_nextSearch = next_set_bit(MAX_RO'(r_mask), {1'b0, r_idx} + 4'd1);

    // A gate setting of zero still opens the gate for one cycle
    assign w_gateLoad = (r_gate == '0) ? '0 : TMR_W'(r_gate - GATE_W'(1));

    ro_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmrLoad),
        .i_load_val (w_tmrVal),
        .o_done     (w_tmrDone)
    );

    // Decode the current index into the one-hot enable pattern
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            w_onehot[i] = (r_idx == 3'(i));
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Sweep configuration, current index and the captured result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask    <= '0;
            r_gate    <= '0;
            r_idx     <= '0;
            r_resData <= '0;
            r_resId   <= '0;
        end else begin
            if (w_latchCfg) begin
                r_mask <= i_ro_mask;
                r_gate <= i_gate_cycles;
            end
            if (w_idxLoad) begin
                r_idx <= w_idxNew;
            end
            if (w_capture) begin
                r_resData <= i_cnt_value;
                r_resId   <= r_idx[ID_W-1:0];
            end
        end
    end

    // Next-state decode, timer loads and per-state outputs
    always_comb begin
        w_stateNext = r_state;
        w_latchCfg  = 1'b0;
        w_idxLoad   = 1'b0;
        w_idxNew    = r_idx;
        w_capture   = 1'b0;
        w_tmrLoad   = 1'b0;
        w_tmrVal    = '0;
        o_ro_en     = '0;
        o_cnt_clear = 1'b0;
        o_cnt_gate  = 1'b0;
        o_res_valid = 1'b0;
        o_busy      = 1'b1;

        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_latchCfg = 1'b1;
                    if (w_lowSearch.found) begin
                        w_idxLoad   = 1'b1;
                        w_idxNew    = w_lowSearch.idx;
                        w_stateNext = S_SELECT;
                    end
                end
            end

            S_SELECT: begin
                o_ro_en     = w_onehot;
                o_cnt_clear = 1'b1;
                w_tmrLoad   = 1'b1;
                w_tmrVal    = TMR_W'(SETTLE_CYC - 1);
                w_stateNext = S_SETTLE;
            end

            S_SETTLE: begin
                o_ro_en = w_onehot;
                if (w_tmrDone) begin
                    w_tmrLoad   = 1'b1;
                    w_tmrVal    = w_gateLoad;
                    w_stateNext = S_GATE;
                end
            end

            S_GATE: begin
                o_ro_en    = w_onehot;
                o_cnt_gate = 1'b1;
                if (w_tmrDone) begin
                    w_tmrLoad   = 1'b1;
                    w_tmrVal    = TMR_W'(DRAIN_CYC - 1);
                    w_stateNext = S_DRAIN;
                end
            end

            S_DRAIN: begin
                o_ro_en = w_onehot;
                if (w_tmrDone) begin
                    w_capture   = 1'b1;
                    w_stateNext = S_REPORT;
                end
            end

            S_REPORT: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    if (w_nextSearch.found) begin
                        w_idxLoad   = 1'b1;
                        w_idxNew    = w_nextSearch.idx;
                        w_stateNext = S_SELECT;
                    end else if (i_continuous) begin
                        w_latchCfg = 1'b1;
                        if (w_lowSearch.found) begin
                            w_idxLoad   = 1'b1;
                            w_idxNew    = w_lowSearch.idx;
                            w_stateNext = S_SELECT;
                        end else begin
                            w_stateNext = S_IDLE;
                        end
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign o_res_data = r_resData;
    assign o_res_id   = r_resId;

endmodule

// File: doc/ro_measure_sequencer.md
Name: ro_measure_sequencer

Overview:
Sequences the ring-oscillator (RO) sensor datapath through a series of measurements. For each oscillator enabled in a mask, it:
- enables that RO and lets it settle;
- opens a counting gate for a programmable number of clk cycles;
- waits for the async edge counter to become stable;
- captures the count and presents it on a valid/ready result port.
It sits between the TT top-level register/IO logic and the RO bank plus edge counter.

Parameters:
- NUM_RO, 4, number of ring oscillators (1..8).
- CNT_W, 16, width of edge counter value.
- GATE_W, 16, width of gate-length setting.
- SETTLE_CYC, 8, clk cycles between RO enable and gate open (>=1).
- DRAIN_CYC, 3, clk cycles between gate close and count capture (covers 2-flop sync, >=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a sweep when IDLE, ignored otherwise.
- continuous  in  1  when 1, a new sweep restarts automatically after the last RO.
- ro_mask  in  NUM_RO  RO selection; sampled at sweep start.
- gate_cycles  in  GATE_W  gate length; sampled at sweep start; 0 is treated as 1.
- ro_en  out  NUM_RO  one-hot RO enable, all 0 when not measuring.
- cnt_clear  out  1  one-cycle clear of the edge counter.
- cnt_gate  out  1  counter enable window.
- cnt_value  in  CNT_W  synchronized counter value.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  CNT_W  captured count.
- res_id  out  $clog2(NUM_RO) (min 1)  index of measured RO.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0; FSM returns to IDLE; latched mask, gate and index are cleared. Reset mid-sweep aborts immediately and drops any pending result.
- States: IDLE, SELECT, SETTLE, GATE, DRAIN, REPORT.
- IDLE: start=1 latches ro_mask and gate_cycles.
  - Latched mask 0: stay IDLE, busy stays 0.
  - Otherwise: idx = lowest set bit, go to SELECT.
- SELECT (1 cycle): ro_en = onehot(idx), cnt_clear=1 → SETTLE.
- SETTLE: ro_en held; counter runs SETTLE_CYC cycles → GATE.
- GATE: cnt_gate=1 for exactly max(gate_cycles,1) cycles → DRAIN.
- DRAIN: cnt_gate=0, ro_en held; DRAIN_CYC cycles → REPORT. On entry to REPORT, res_data<=cnt_value and res_id<=idx.
- REPORT: res_valid=1 and ro_en=0. res_data and res_id stay stable until res_valid&&res_ready.
  - On handshake: res_valid drops the next cycle.
  - Higher set mask bit exists: idx = next higher set bit, go to SELECT.
  - Else if continuous=1: re-latch ro_mask and gate_cycles, idx = lowest bit, go to SELECT (IDLE if the new mask is 0).
  - Else: go to IDLE.
- res_ready held high: back-to-back results, one handshake cycle each; no result is lost or duplicated.
- Per-RO latency from SELECT to res_valid rising = 1 + SETTLE_CYC + gate + DRAIN_CYC cycles.
- start while busy: ignored. continuous dropping mid-sweep: the current sweep finishes, then IDLE.
- Count arithmetic: no saturation in the sequencer; counter overflow wraps in the counter and is passed through as-is.
- Only one ro_en bit is ever high. ro_en is 0 in IDLE and REPORT, so there is no oscillator power while stalled.

Decomposition:
- Package ro_seq_pkg:
  - state enum typedef;
  - default constants for SETTLE_CYC and DRAIN_CYC;
  - function next_set_bit(mask, from), returning found flag and index.
- One sub-module ro_seq_timer: a loadable down-counter with done flag. It is shared by SETTLE, GATE and DRAIN, with width max(GATE_W, clog2 of the constants).

Test Plan:
- ro_mask=4'b0101, gate_cycles=10, start pulse, res_ready=1, cnt_value model = 3×gate cycles:
  - results id0 then id2, data 30 each;
  - cnt_gate high exactly 10 cycles per RO;
  - busy falls after the second handshake.
- gate_cycles=0, ro_mask=4'b0001 → cnt_gate high exactly 1 cycle; one result.
- res_ready=0 for 20 cycles in REPORT → res_valid, res_data and res_id stable; ro_en=0; no further cnt_clear; raising res_ready completes the sweep.
- continuous=1, ro_mask=4'b1000, three sweeps:
  - three id3 results;
  - change gate_cycles mid-sweep: the new value applies only from the next sweep;
  - drop continuous → IDLE after the current result.
- Assert rst during GATE → next cycle all outputs 0 and state IDLE; a start afterwards runs a normal sweep.
- ro_mask=0 with start → busy stays 0, no ro_en activity. start pulsed while busy → ignored, and the result count equals the mask popcount.
